// File: rtl/input_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : input_frame_buffer
//  Description : Hunts a sync byte, captures NUM_INPUTS payload bytes into a
//                local buffer, verifies a trailing XOR checksum and holds the
//                verified frame for random-access reads until released.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_frame_buffer #(
  parameter int          NUM_INPUTS = 16,
  parameter int          AW         = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_ready,
  input  logic          frame_release,
  output logic          frame_err,
  output logic          overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [AW-1:0] C_LAST_IDX    = AW'(NUM_INPUTS - 1);
  localparam logic [AW:0]   C_NUM_INPUTS  = (AW + 1)'(NUM_INPUTS);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_count;
  logic [7:0]    r_csum;
  logic [7:0]    r_buf [NUM_INPUTS];
  logic [7:0]    r_rd_data;
  logic          r_frame_err;
  logic          r_overflow;

  logic          w_start;
  logic          w_wr_en;
  logic          w_err;
  logic          w_ovf;
  logic          w_is_sync;
  logic          w_addr_ok;

  assign w_is_sync = byte_valid && (byte_in == SYNC_BYTE);
  assign w_addr_ok = ({1'b0, rd_addr} < C_NUM_INPUTS);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; a release in HOLD lets the same-cycle
  // byte be treated as if the FSM were already idle
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wr_en     = 1'b0;
    w_err       = 1'b0;
    w_ovf       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_sync) begin
          w_state_nxt = S_LOAD;
          w_start     = 1'b1;
        end
      end
      S_LOAD: begin
        if (byte_valid) begin
          w_wr_en = 1'b1;
          if (r_count == C_LAST_IDX) begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (byte_valid) begin
          if (byte_in == r_csum) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (frame_release) begin
          w_state_nxt = S_IDLE;
          if (w_is_sync) begin
            w_state_nxt = S_LOAD;
            w_start     = 1'b1;
          end
        end else if (byte_valid) begin
          w_ovf = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Byte counter, running checksum and status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_csum      <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_start) begin
        r_count <= '0;
        r_csum  <= '0;
      end else if (w_wr_en) begin
        r_count <= r_count + 1'b1;
        r_csum  <= r_csum ^ byte_in;
      end
    end
  end

  // Payload storage; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_count] <= byte_in;
    end
  end

  // Registered read port, out-of-range addresses read as zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (w_addr_ok) begin
      r_rd_data <= r_buf[rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data     = r_rd_data;
  assign frame_ready = (r_state == S_HOLD);
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire
